// File: rtl/snitch_ro_cache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// snitch_ro_cache_flush_ctrl
//
// Sequences flush and enable for the read-only constant cache. Several
// requesters (cores, DMA, control registers) share the single cache flush
// port. A flush round works as follows:
//   1. The controller captures every requester that is valid while idle.
//   2. It drops the cache enable so that new reads bypass the cache.
//   3. It waits until every in-flight cached read has drained.
//   4. It runs the flush handshake with the cache.
//   5. It acknowledges the captured requesters, then re-enables the cache.
//
// Ports:
//   clk_i               clock
//   rst_i               synchronous, active-high reset
//   enable_i            software cache enable
//   req_flush_valid_i   per-requester flush request, held until acknowledged
//   req_flush_ready_o   per-requester one-cycle completion pulse
//   ar_hs_i             AR handshake seen on the cache-path port
//   r_last_hs_i         last-R-beat handshake seen on the cache-path port
//   cache_enable_o      to the cache enable input (registered)
//   cache_flush_valid_o to the cache flush_valid input (registered)
//   cache_flush_ready_i from the cache flush_ready output
//   busy_o              high whenever a flush round is in progress
//   outstanding_o       current number of in-flight cached reads
// -----------------------------------------------------------------------------
module snitch_ro_cache_flush_ctrl #(
  parameter  int unsigned NrRequesters   = 4,
  parameter  int unsigned MaxOutstanding = 8,
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [NrRequesters-1:0] req_flush_valid_i,
  output logic [NrRequesters-1:0] req_flush_ready_o,
  input  logic                    ar_hs_i,
  input  logic                    r_last_hs_i,
  output logic                    cache_enable_o,
  output logic                    cache_flush_valid_o,
  input  logic                    cache_flush_ready_i,
  output logic                    busy_o,
  output logic [CntWidth-1:0]     outstanding_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Drain = 2'd1,
    Flush = 2'd2,
    Ack   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CntWidth-1:0]     outstanding_q, outstanding_d;
  logic [NrRequesters-1:0] served_mask_q, served_mask_d;
  logic                    cache_enable_q;
  logic                    cache_flush_valid_q;
  logic [NrRequesters-1:0] req_ready;

  // ---------------------------------------------------------------------------
  // In-flight read counter. It runs in every state, so reads issued just
  // before the enable drops are still tracked. An AR and a last R beat in the
  // same cycle cancel out. An overflow or underflow is a protocol violation;
  // the counter saturates instead of wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs_i && !r_last_hs_i) begin
      if (outstanding_q != CntMax) begin
        outstanding_d = outstanding_q + CntOne;
      end
    end else if (!ar_hs_i && r_last_hs_i) begin
      if (outstanding_q != '0) begin
        outstanding_d = outstanding_q - CntOne;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flush sequencing FSM: next state and acknowledge outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    served_mask_d = served_mask_q;
    req_ready     = '0;
    unique case (state_q)
      Idle: begin
        // Every requester valid in this cycle is served by the same flush.
        // Requests raised later wait for the next round.
        if (|req_flush_valid_i) begin
          served_mask_d = req_flush_valid_i;
          state_d       = Drain;
        end
      end
      Drain: begin
        // The cache enable falls one cycle after capture, so an AR can still
        // be accepted in the first Drain cycle. An AR in the current cycle
        // also blocks the exit until it has been counted and drained.
        if ((outstanding_q == '0) && !ar_hs_i) begin
          state_d = Flush;
        end
      end
      Flush: begin
        if (cache_flush_ready_i) begin
          state_d = Ack;
        end
      end
      Ack: begin
        req_ready = served_mask_q;
        state_d   = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Both cache-facing outputs are registered
  // from the next state. As a result, flush_valid holds high throughout
  // Flush and falls only after ready has been seen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q             <= Idle;
      outstanding_q       <= '0;
      served_mask_q       <= '0;
      cache_enable_q      <= 1'b0;
      cache_flush_valid_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      outstanding_q       <= outstanding_d;
      served_mask_q       <= served_mask_d;
      cache_enable_q      <= enable_i && (state_d == Idle);
      cache_flush_valid_q <= (state_d == Flush);
    end
  end

  assign req_flush_ready_o   = req_ready;
  assign cache_enable_o      = cache_enable_q;
  assign cache_flush_valid_o = cache_flush_valid_q;
  assign busy_o              = (state_q != Idle);
  assign outstanding_o       = outstanding_q;

  // ---------------------------------------------------------------------------
  // Protocol checks on the in-flight counter.
  // ---------------------------------------------------------------------------
  counter_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ar_hs_i && !r_last_hs_i && (outstanding_q == CntMax)));

  counter_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(!ar_hs_i && r_last_hs_i && (outstanding_q == '0)));

endmodule

// File: tb/tb_snitch_ro_cache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for snitch_ro_cache_flush_ctrl.
// Table-driven per-cycle vectors cover reset, the minimum-latency flush,
// drain waiting, counter corner cases and operation with the enable low.
// Hand-written sequences cover batching, a slow cache and a reset during
// Flush. Expected acknowledge masks go into a queue and are checked against
// each ready pulse.
// -----------------------------------------------------------------------------
module tb_snitch_ro_cache_flush_ctrl;

  localparam int unsigned NrReq  = 4;
  localparam int unsigned MaxOut = 8;
  localparam int unsigned CW     = $clog2(MaxOut + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NrReq-1:0] req_valid;
  logic [NrReq-1:0] req_ready;
  logic             ar_hs;
  logic             r_last_hs;
  logic             cache_enable;
  logic             cache_flush_valid;
  logic             cache_flush_ready;
  logic             busy;
  logic [CW-1:0]    outstanding;

  snitch_ro_cache_flush_ctrl #(
    .NrRequesters  (NrReq),
    .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .req_flush_valid_i  (req_valid),
    .req_flush_ready_o  (req_ready),
    .ar_hs_i            (ar_hs),
    .r_last_hs_i        (r_last_hs),
    .cache_enable_o     (cache_enable),
    .cache_flush_valid_o(cache_flush_valid),
    .cache_flush_ready_i(cache_flush_ready),
    .busy_o             (busy),
    .outstanding_o      (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [3:0] req;
    logic       ar;
    logic       rl;
    logic       rdy;
    logic       exp_en;
    logic       exp_fv;
    logic [3:0] exp_ack;
    logic       exp_busy;
    logic [3:0] exp_out;
  } vec_t;

  vec_t       vecs[$];
  vec_t       exp_q[$];
  logic [3:0] ack_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         hs_cnt = 0;
  int         fv_cnt = 0;
  logic [3:0] req_model = '0;

  function automatic vec_t mk(input int en, input int req, input int ar,
                              input int rl, input int rdy, input int e_en,
                              input int e_fv, input int e_ack, input int e_busy,
                              input int e_out);
    vec_t r;
    r.en       = en[0];
    r.req      = req[3:0];
    r.ar       = ar[0];
    r.rl       = rl[0];
    r.rdy      = rdy[0];
    r.exp_en   = e_en[0];
    r.exp_fv   = e_fv[0];
    r.exp_ack  = e_ack[3:0];
    r.exp_busy = e_busy[0];
    r.exp_out  = e_out[3:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one vector just after the rising edge, then compare outputs at the
  // falling edge of the same cycle. The compared field order is:
  // {cache_enable, flush_valid, ack[3:0], busy, outstanding[3:0]}.
  task automatic apply_vec(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    enable            = v.en;
    req_valid         = v.req;
    ar_hs             = v.ar;
    r_last_hs         = v.rl;
    cache_flush_ready = v.rdy;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("vec%0d", idx),
          32'({cache_enable, cache_flush_valid, req_ready, busy, outstanding}),
          32'({e.exp_en, e.exp_fv, e.exp_ack, e.exp_busy, e.exp_out}));
  endtask

  // One cycle of the requester model. Requests come from req_model. Each
  // ready pulse is checked against the oldest expected mask and releases the
  // acknowledged requesters for the following cycle.
  task automatic step_seq(input logic ar, input logic rl, input logic rdy, input logic r);
    logic [3:0] exp_ack;
    @(posedge clk);
    #1;
    rst               = r;
    ar_hs             = ar;
    r_last_hs         = rl;
    cache_flush_ready = rdy;
    req_valid         = req_model;
    @(negedge clk);
    if (cache_flush_valid && cache_flush_ready) hs_cnt++;
    if (req_ready != '0) begin
      if (ack_q.size() == 0) begin
        check("ack_unexpected", 32'(req_ready), 32'(0));
      end else begin
        exp_ack = ack_q.pop_front();
        check("ack_mask", 32'(req_ready), 32'(exp_ack));
      end
      req_model = req_model & ~req_ready;
    end
  endtask

  task automatic run_to_idle(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_seq(1'b0, 1'b0, 1'b1, 1'b0);
      if (ack_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    enable            = 1'b0;
    req_valid         = '0;
    ar_hs             = 1'b0;
    r_last_hs         = 1'b0;
    cache_flush_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //            en req     ar rl rdy | en fv ack     bsy out
    // First cycle after reset, then a minimum-latency flush.
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 0, 0, 'b0000, 0, 0));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 1, 0, 'b0000, 0, 0));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 0, 0, 'b0000, 1, 0));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 0, 1, 'b0000, 1, 0));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 0, 0, 'b0001, 1, 0));
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 1, 0, 'b0000, 0, 0));
    // Three reads in flight, then a request waits in Drain.
    vecs.push_back(mk(1, 'b0000, 1, 0, 1, 1, 0, 'b0000, 0, 0));
    vecs.push_back(mk(1, 'b0000, 1, 0, 1, 1, 0, 'b0000, 0, 1));
    vecs.push_back(mk(1, 'b0000, 1, 0, 1, 1, 0, 'b0000, 0, 2));
    vecs.push_back(mk(1, 'b0010, 0, 0, 1, 1, 0, 'b0000, 0, 3));
    vecs.push_back(mk(1, 'b0010, 0, 0, 1, 0, 0, 'b0000, 1, 3));
    vecs.push_back(mk(1, 'b0010, 0, 1, 1, 0, 0, 'b0000, 1, 3));
    vecs.push_back(mk(1, 'b0010, 0, 1, 1, 0, 0, 'b0000, 1, 2));
    vecs.push_back(mk(1, 'b0010, 0, 1, 1, 0, 0, 'b0000, 1, 1));
    vecs.push_back(mk(1, 'b0010, 0, 0, 1, 0, 0, 'b0000, 1, 0));
    vecs.push_back(mk(1, 'b0010, 0, 0, 1, 0, 1, 'b0000, 1, 0));
    vecs.push_back(mk(1, 'b0010, 0, 0, 1, 0, 0, 'b0010, 1, 0));
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 1, 0, 'b0000, 0, 0));
    // An AR and a last R beat in the same cycle leave the count unchanged.
    vecs.push_back(mk(1, 'b0000, 1, 0, 1, 1, 0, 'b0000, 0, 0));
    vecs.push_back(mk(1, 'b0000, 1, 0, 1, 1, 0, 'b0000, 0, 1));
    vecs.push_back(mk(1, 'b0000, 1, 1, 1, 1, 0, 'b0000, 0, 2));
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 1, 0, 'b0000, 0, 2));
    vecs.push_back(mk(1, 'b0000, 0, 1, 1, 1, 0, 'b0000, 0, 2));
    vecs.push_back(mk(1, 'b0000, 0, 1, 1, 1, 0, 'b0000, 0, 1));
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 1, 0, 'b0000, 0, 0));
    // A late AR in the first Drain cycle.
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 1, 0, 'b0000, 0, 0));
    vecs.push_back(mk(1, 'b0001, 1, 0, 1, 0, 0, 'b0000, 1, 0));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 0, 0, 'b0000, 1, 1));
    vecs.push_back(mk(1, 'b0001, 0, 1, 1, 0, 0, 'b0000, 1, 1));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 0, 0, 'b0000, 1, 0));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 0, 1, 'b0000, 1, 0));
    vecs.push_back(mk(1, 'b0001, 0, 0, 1, 0, 0, 'b0001, 1, 0));
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 1, 0, 'b0000, 0, 0));
    // Software enable low: the round still completes and the cache stays off.
    vecs.push_back(mk(0, 'b1000, 0, 0, 1, 1, 0, 'b0000, 0, 0));
    vecs.push_back(mk(0, 'b1000, 0, 0, 1, 0, 0, 'b0000, 1, 0));
    vecs.push_back(mk(0, 'b1000, 0, 0, 1, 0, 1, 'b0000, 1, 0));
    vecs.push_back(mk(0, 'b1000, 0, 0, 1, 0, 0, 'b1000, 1, 0));
    vecs.push_back(mk(0, 'b0000, 0, 0, 1, 0, 0, 'b0000, 0, 0));
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 0, 0, 'b0000, 0, 0));
    vecs.push_back(mk(1, 'b0000, 0, 0, 1, 1, 0, 'b0000, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], i);
    end

    // Batching: 0101 is captured; 1000 is raised during Drain and gets its own round.
    hs_cnt    = 0;
    req_model = 4'b0101;
    ack_q.push_back(4'b0101);
    step_seq(1'b0, 1'b0, 1'b1, 1'b0);
    req_model = req_model | 4'b1000;
    ack_q.push_back(4'b1000);
    run_to_idle(40, "batch_done");
    check("batch_handshakes", 32'(hs_cnt), 32'(2));

    // Slow cache: ready is held low for 10 Flush cycles.
    hs_cnt    = 0;
    req_model = 4'b0100;
    ack_q.push_back(4'b0100);
    step_seq(1'b0, 1'b0, 1'b0, 1'b0);
    step_seq(1'b0, 1'b0, 1'b0, 1'b0);
    fv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_seq(1'b0, 1'b0, 1'b0, 1'b0);
      if (cache_flush_valid === 1'b1) fv_cnt++;
    end
    step_seq(1'b0, 1'b0, 1'b1, 1'b0);
    if (cache_flush_valid === 1'b1) fv_cnt++;
    check("slow_valid_cycles", 32'(fv_cnt), 32'(11));
    step_seq(1'b0, 1'b0, 1'b1, 1'b0);
    check("slow_ack_timing", 32'(req_ready), 32'(4'b0100));
    check("slow_valid_dropped", 32'(cache_flush_valid), 32'(0));
    run_to_idle(20, "slow_done");
    check("slow_handshakes", 32'(hs_cnt), 32'(1));

    // Reset while the flush handshake is pending at the cache.
    hs_cnt    = 0;
    req_model = 4'b0010;
    ack_q.push_back(4'b0010);
    step_seq(1'b0, 1'b0, 1'b0, 1'b0);
    step_seq(1'b0, 1'b0, 1'b0, 1'b0);
    step_seq(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_pre_valid", 32'(cache_flush_valid), 32'(1));
    step_seq(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_pre_outstanding", 32'(outstanding), 32'(1));
    step_seq(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_outputs_cleared",
          32'({cache_enable, cache_flush_valid, req_ready, busy, outstanding}), 32'(0));
    run_to_idle(40, "rst_restart_done");
    check("rst_handshakes", 32'(hs_cnt), 32'(1));
    check("final_cache_enable", 32'(cache_enable), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
